// File: rtl/alu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared definitions for the ALU arbiter slice: ALU opcode encodings
// (mirrors the ALU's own opcode table), the idle opcode driven when nothing
// is granted, requester identifiers and the flag bundle held in each
// response buffer.
// ---------------------------------------------------------------------------
package alu_arbiter_pkg;

    localparam int ALU_XLEN = 32;
    localparam int ALU_OPW  = 5;

    // ALU opcode encodings.
    localparam logic [ALU_OPW-1:0] ALU_ADD  = 5'h00;
    localparam logic [ALU_OPW-1:0] ALU_SUB  = 5'h01;
    localparam logic [ALU_OPW-1:0] ALU_AND  = 5'h02;
    localparam logic [ALU_OPW-1:0] ALU_OR   = 5'h03;
    localparam logic [ALU_OPW-1:0] ALU_XOR  = 5'h04;
    localparam logic [ALU_OPW-1:0] ALU_SLT  = 5'h05;
    localparam logic [ALU_OPW-1:0] ALU_SLTU = 5'h06;
    localparam logic [ALU_OPW-1:0] ALU_SLL  = 5'h07;
    localparam logic [ALU_OPW-1:0] ALU_SRL  = 5'h08;
    localparam logic [ALU_OPW-1:0] ALU_SRA  = 5'h09;

    // Matches no real op, so the ALU falls into its default branch and
    // produces zero while it is not in use.
    localparam logic [ALU_OPW-1:0] ALU_IDLE_OP = 5'h1F;

    // Requester identity, used for the in-flight owner tag.
    typedef enum logic [0:0] {
        REQ_R0 = 1'b0,
        REQ_R1 = 1'b1
    } req_id_e;

    // Flags captured alongside each buffered result.
    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
    } alu_flags_t;

    // Bundle the three ALU flag wires into the buffered flag record.
    function automatic alu_flags_t pack_flags(input logic carry,
                                              input logic overflow,
                                              input logic zero);
        alu_flags_t f;
        f.carry    = carry;
        f.overflow = overflow;
        f.zero     = zero;
        return f;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// alu_arbiter_rr_arb2
// Two-way round-robin grant. A lone requester always wins; on contention
// the requester named by the pointer wins and the pointer then moves to
// the other one. The pointer holds whenever there is no contention.
//
// Ports:
//   clk    - clock
//   reset  - synchronous active-low reset (pointer back to requester 0)
//   req    - per-requester eligibility, bit i = requester i
//   grant  - one-hot (or zero) grant, combinational from req and pointer
// ---------------------------------------------------------------------------
module alu_arbiter_rr_arb2
    import alu_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    req_id_e ptr_r;
    logic    contend_s;

    // Contention detect: both requesters eligible in the same cycle.
    always_comb begin
        contend_s = 1'b0;
        if (req == 2'b11) begin
            contend_s = 1'b1;
        end else begin
            contend_s = 1'b0;
        end
    end

    // Grant select: single requester passes through, contention follows the pointer.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
                if (ptr_r == REQ_R1) begin
                    grant = 2'b10;
                end else begin
                    grant = 2'b01;
                end
            end
            default: grant = 2'b00;
        endcase
    end

    // Pointer update: the contention winner gives priority to the other side.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_r <= REQ_R0;
        end else if (contend_s) begin
            ptr_r <= (ptr_r == REQ_R0) ? REQ_R1 : REQ_R0;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one registered ALU between the issue pipeline (r0) and the
// branch/address unit (r1). Each cycle at most one eligible requester is
// granted; its op and operands go straight to the ALU, which registers
// them at the issue edge. One edge later the ALU outputs are captured into
// the owner's one-entry response buffer and offered back under a
// valid/ready handshake.
//
// Ports:
//   clk, reset                       - clock, synchronous active-low reset
//   rN_valid / rN_ready              - request handshake (ready = grant)
//   rN_op, rN_rs1, rN_rs2            - request op and operands
//   rN_resp_valid / rN_resp_ready    - response handshake
//   rN_result, rN_carry,
//   rN_overflow, rN_zero             - buffered response (registered)
//   alu_op, alu_rs1, alu_rs2         - drive to the ALU
//   alu_result, alu_carry,
//   alu_overflow, alu_zero           - registered ALU outputs
// ---------------------------------------------------------------------------
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter logic [4:0] IDLE_OP = ALU_IDLE_OP,
    parameter int         XLEN    = ALU_XLEN
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            r0_valid,
    output logic            r0_ready,
    input  logic [4:0]      r0_op,
    input  logic [XLEN-1:0] r0_rs1,
    input  logic [XLEN-1:0] r0_rs2,
    output logic            r0_resp_valid,
    input  logic            r0_resp_ready,
    output logic [XLEN-1:0] r0_result,
    output logic            r0_carry,
    output logic            r0_overflow,
    output logic            r0_zero,

    input  logic            r1_valid,
    output logic            r1_ready,
    input  logic [4:0]      r1_op,
    input  logic [XLEN-1:0] r1_rs1,
    input  logic [XLEN-1:0] r1_rs2,
    output logic            r1_resp_valid,
    input  logic            r1_resp_ready,
    output logic [XLEN-1:0] r1_result,
    output logic            r1_carry,
    output logic            r1_overflow,
    output logic            r1_zero,

    output logic [XLEN-1:0] alu_rs1,
    output logic [XLEN-1:0] alu_rs2,
    output logic [4:0]      alu_op,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_carry,
    input  logic            alu_overflow,
    input  logic            alu_zero
);

    logic            inflight_r;
    req_id_e         owner_r;
    logic [1:0]      resp_valid_r;
    logic [XLEN-1:0] result_r [2];
    alu_flags_t      flags_r  [2];

    logic [1:0]      resp_ready_s;
    logic [1:0]      busy_s;
    logic [1:0]      elig_s;
    logic [1:0]      grant_s;
    logic            issue_s;
    req_id_e         winner_s;

    assign resp_ready_s = {r1_resp_ready, r0_resp_ready};

    // Busy: op in flight for this requester, or a full buffer not being drained.
    // A buffer drained at this edge may be refilled by the capture one edge later,
    // so a new request can be accepted in the very cycle the old response leaves.
    always_comb begin
        busy_s = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (inflight_r && (owner_r == req_id_e'(i[0]))) begin
                busy_s[i] = 1'b1;
            end else if (resp_valid_r[i] && !resp_ready_s[i]) begin
                busy_s[i] = 1'b1;
            end else begin
                busy_s[i] = 1'b0;
            end
        end
    end

    // Eligibility only looks at registered state and the handshake inputs,
    // so nothing from the ALU result can reach the ready outputs.
    assign elig_s = {r1_valid, r0_valid} & ~busy_s;

    alu_arbiter_rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .reset (reset),
        .req   (elig_s),
        .grant (grant_s)
    );

    assign r0_ready = grant_s[0];
    assign r1_ready = grant_s[1];
    assign issue_s  = grant_s[0] | grant_s[1];
    assign winner_s = grant_s[1] ? REQ_R1 : REQ_R0;

    // ALU drive mux: winner's op and operands, or the idle op with zero operands.
    always_comb begin
        alu_op  = IDLE_OP;
        alu_rs1 = {XLEN{1'b0}};
        alu_rs2 = {XLEN{1'b0}};
        case (grant_s)
            2'b01: begin
                alu_op  = r0_op;
                alu_rs1 = r0_rs1;
                alu_rs2 = r0_rs2;
            end
            2'b10: begin
                alu_op  = r1_op;
                alu_rs1 = r1_rs1;
                alu_rs2 = r1_rs2;
            end
            default: begin
                alu_op  = IDLE_OP;
                alu_rs1 = {XLEN{1'b0}};
                alu_rs2 = {XLEN{1'b0}};
            end
        endcase
    end

    // In-flight tracking: a new issue at the capture edge keeps the slot busy
    // and retags it with the new winner.
    always_ff @(posedge clk) begin
        if (!reset) begin
            inflight_r <= 1'b0;
            owner_r    <= REQ_R0;
        end else if (issue_s) begin
            inflight_r <= 1'b1;
            owner_r    <= winner_s;
        end else begin
            inflight_r <= 1'b0;
            owner_r    <= owner_r;
        end
    end

    // Response buffers: drain on handshake, capture ALU output for the owner.
    // The busy rule keeps the owner's buffer empty at its capture edge, so a
    // drain and a capture never target the same full entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_valid_r <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                result_r[i] <= {XLEN{1'b0}};
                flags_r[i]  <= pack_flags(1'b0, 1'b0, 1'b0);
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (inflight_r && (owner_r == req_id_e'(i[0]))) begin
                    resp_valid_r[i] <= 1'b1;
                    result_r[i]     <= alu_result;
                    flags_r[i]      <= pack_flags(alu_carry, alu_overflow, alu_zero);
                end else if (resp_valid_r[i] && resp_ready_s[i]) begin
                    resp_valid_r[i] <= 1'b0;
                    result_r[i]     <= result_r[i];
                    flags_r[i]      <= flags_r[i];
                end else begin
                    resp_valid_r[i] <= resp_valid_r[i];
                    result_r[i]     <= result_r[i];
                    flags_r[i]      <= flags_r[i];
                end
            end
        end
    end

    assign r0_resp_valid = resp_valid_r[0];
    assign r0_result     = result_r[0];
    assign r0_carry      = flags_r[0].carry;
    assign r0_overflow   = flags_r[0].overflow;
    assign r0_zero       = flags_r[0].zero;

    assign r1_resp_valid = resp_valid_r[1];
    assign r1_result     = result_r[1];
    assign r1_carry      = flags_r[1].carry;
    assign r1_overflow   = flags_r[1].overflow;
    assign r1_zero       = flags_r[1].zero;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single registered ALU between two requesters: r0 (issue pipeline) and r1 (branch/address unit).
- Arbitrates with round-robin priority and drives the ALU operand and op inputs.
- Tracks which requester owns the op in flight and captures the ALU result and flags into a one-entry response buffer per requester.
- Returns each response to its owner under a valid/ready handshake.

Parameters:
- IDLE_OP, 5'h1F, opcode driven to the ALU when nothing is granted. Must not match any op in alu_ops.vh, so the ALU takes its default branch and outputs 0.
- XLEN, 32, operand/result width. Fixed to the ALU width; present only for readability.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset.
- r0_valid / r1_valid  input  1  request valid.
- r0_ready / r1_ready  output  1  request accepted this cycle.
- r0_op / r1_op  input  5  ALU op, encoded per alu_ops.vh.
- r0_rs1, r0_rs2 / r1_rs1, r1_rs2  input  32  operands.
- r0_resp_valid / r1_resp_valid  output  1  response buffer full.
- r0_resp_ready / r1_resp_ready  input  1  owner consumes the response.
- r0_result / r1_result  output  32  buffered result.
- r0_carry, r0_overflow, r0_zero / r1_carry, r1_overflow, r1_zero  output  1  buffered flags.
- alu_rs1, alu_rs2  output  32  to ALU.
- alu_op  output  5  to ALU.
- alu_result  input  32  from ALU.
- alu_carry, alu_overflow, alu_zero  input  1  from ALU.

Behaviour:
- Clocking and reset: one clock `clk`; reset `reset` is synchronous, active-low.
  - Sampled low at a posedge, reset clears all state: inflight=0, owner=0, rr_ptr=0 (r0 has priority), both resp buffers empty, result/flags=0.
  - Requests and responses in progress are dropped without notice.
- Busy rule: busy_i = inflight_i | (ri_resp_valid & ~ri_resp_ready).
  - A response drained at edge N frees the buffer for a capture at edge N+1.
- Eligibility: elig_i = ri_valid & ~busy_i. Each requester has at most one op outstanding.
- Grant (combinational from registered state, valid and resp_ready):
  - Only one eligible requester: it wins.
  - Both eligible: the one pointed to by rr_ptr wins.
  - ri_ready = grant_i. At most one ready per cycle.
- ALU drive:
  - Granted: alu_op/alu_rs1/alu_rs2 = the winner's op/rs1/rs2.
  - Otherwise: alu_op=IDLE_OP, alu_rs1=0, alu_rs2=0.
- Issue at edge N (ri_valid & ri_ready):
  - The ALU samples the operands at edge N.
  - inflight<=1 and owner<=i.
  - rr_ptr<=~i, but only when both requesters were eligible. Otherwise rr_ptr holds.
- Capture at edge N+1 when inflight=1:
  - alu_result, alu_carry, alu_overflow and alu_zero are written into buffer[owner], and resp_valid[owner]<=1.
  - inflight<=0, unless a new grant issues at this same edge, in which case inflight stays 1 and owner takes the new winner.
- Latency: accept at edge N, resp_valid high from edge N+1. Sustained throughput:
  - 1 op/cycle across both requesters when they alternate;
  - 1 op per 2 cycles for a single requester.
- Response drain: ri_resp_valid & ri_resp_ready at an edge clears resp_valid_i. Capture into that buffer at the same edge is impossible by the busy rule.
- Flags are passed through unmodified; the ALU gates carry and overflow to ADD/SUB only.
- No combinational path from alu_result to any ri_ready.

Decomposition:
- Shared package/header: reuse alu_ops.vh for op encodings; add an ALU_IDLE_OP define there.
- Natural sub-module: rr_arb2, a two-way round-robin grant with pointer update-on-contention.
- Response buffers stay inline.

Test Plan:
- Reset, then r0 `ADD rs1=5 rs2=7 -> r0_ready=1 in that cycle; r0_resp_valid high from the next edge; result=12, carry=0, overflow=0, zero=0.
- Both valid: r0 `SUB 3,3 and r1 `AND 0xF0,0x0F -> r0 granted first (rr_ptr=0), r1 the following cycle.
  - r0 response: result=0, zero=1, carry=1.
  - r1 response: result=0, zero=1, carry=0.
- r0 `ADD 0x7FFFFFFF,1 with r0_resp_ready held 0 -> resp held; result=0x80000000, overflow=1; r0_ready stays 0 for a second r0 request until resp_ready pulses.
- Back-to-back same requester: r1 `SLT 0xFFFFFFFF,1 with resp_ready=1 -> result=1; next r1 op accepted 2 cycles after the first; no accept in the cycle between.
- Idle cycles -> alu_op=IDLE_OP, operands 0, no resp_valid asserted.
- Reset asserted the cycle after r0 issue -> no r0 resp_valid ever; rr_ptr=0; the next request is accepted normally.
